// File: rtl/btp_pkg.sv
// Branch target predictor shared types: FSM state, 2-bit counter
// encodings, saturating helpers and the per-entry control struct.
package btp_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } btp_state_e;

  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;
  localparam logic [1:0] ALLOC     = 2'b10;

  function automatic logic [1:0] sat_inc(
    input logic [1:0] c
  );
    return (c == STRONG_T) ? STRONG_T : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(
    input logic [1:0] c
  );
    return (c == STRONG_NT) ? STRONG_NT : c - 2'd1;
  endfunction

  // Tag and target widths follow module parameters, so they are
  // stored beside this struct rather than inside it.
`ifdef BTP_HYST_EN
  typedef struct packed {
    logic       valid;
    logic [1:0] cnt;
  } btp_entry_t;
`else
  typedef struct packed {
    logic valid;
  } btp_entry_t;
`endif

endpackage

// File: rtl/btp_table.sv
// BTB storage: two async read ports (lookup, update), one sync
// write port, and a valid-clear port used by the init sweep.
module btp_table
  import btp_pkg::*;
#(
  parameter int ENTRIES = 1024,
  parameter int IDX_W   = 10,
  parameter int TAG_W   = 5,
  parameter int PC_W    = 16
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] ra_idx,
  output btp_entry_t       ra_ent,
  output logic [TAG_W-1:0] ra_tag,
  output logic [PC_W-1:0]  ra_tgt,
  input  logic [IDX_W-1:0] rb_idx,
  output btp_entry_t       rb_ent,
  output logic [TAG_W-1:0] rb_tag,
  output logic [PC_W-1:0]  rb_tgt,
  input  logic             we,
  input  logic [IDX_W-1:0] wa_idx,
  input  btp_entry_t       w_ent,
  input  logic [TAG_W-1:0] w_tag,
  input  logic [PC_W-1:0]  w_tgt,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);

  btp_entry_t       r_ent [ENTRIES];
  logic [TAG_W-1:0] r_tag [ENTRIES];
  logic [PC_W-1:0]  r_tgt [ENTRIES];

  assign ra_ent = r_ent[ra_idx];
  assign ra_tag = r_tag[ra_idx];
  assign ra_tgt = r_tgt[ra_idx];
  assign rb_ent = r_ent[rb_idx];
  assign rb_tag = r_tag[rb_idx];
  assign rb_tgt = r_tgt[rb_idx];

  always_ff @(posedge clk) begin
    if (clr_en) begin
      r_ent[clr_idx].valid <= 1'b0;
    end else if (we) begin
      r_ent[wa_idx] <= w_ent;
      r_tag[wa_idx] <= w_tag;
      r_tgt[wa_idx] <= w_tgt;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Tagged branch target buffer with init sweep and saturating stats.
// Ports: clk, rst (sync, active high), ready; lookup lk_valid/lk_pc ->
// lk_hit/lk_target (combinational); training up_valid/up_pc/up_taken/
// up_target/up_mispredict; stat_lookups, stat_mispredicts.
// Define BTP_HYST_EN for 2-bit hysteresis counters per entry.
module branch_target_predictor
  import btp_pkg::*;
#(
  parameter int ENTRIES = 1024,
  parameter int PC_W    = 16,
  parameter int TAG_W   = 5,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              lk_valid,
  input  logic [PC_W-1:0]   lk_pc,
  output logic              lk_hit,
  output logic [PC_W-1:0]   lk_target,
  input  logic              up_valid,
  input  logic [PC_W-1:0]   up_pc,
  input  logic              up_taken,
  input  logic [PC_W-1:0]   up_target,
  input  logic              up_mispredict,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  btp_state_e       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [STAT_W-1:0] r_lk_cnt;
  logic [STAT_W-1:0] r_mp_cnt;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  btp_entry_t       w_ra_ent;
  logic [TAG_W-1:0] w_ra_tag;
  logic [PC_W-1:0]  w_ra_tgt;
  btp_entry_t       w_rb_ent;
  logic [TAG_W-1:0] w_rb_tag;
  logic [PC_W-1:0]  w_rb_tgt;
  logic             w_ready;
  logic             w_lk_hit;
  logic             w_lk_take;
  logic             w_up_hit;
  logic             w_we;
  btp_entry_t       w_wr_ent;
  logic [PC_W-1:0]  w_wr_tgt;
  logic             w_clr;
  logic             w_unused_up;

  assign w_lk_idx = lk_pc[IDX_W:1];
  assign w_lk_tag = lk_pc[IDX_W+TAG_W:IDX_W+1];
  assign w_up_idx = up_pc[IDX_W:1];
  assign w_up_tag = up_pc[IDX_W+TAG_W:IDX_W+1];
  assign w_unused_up = ^up_pc;

  assign w_ready = (r_state == S_RUN);
  assign w_clr   = (r_state == S_INIT) & ~rst;

  btp_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W),
    .PC_W    (PC_W)
  ) u_table (
    .clk     (clk),
    .ra_idx  (w_lk_idx),
    .ra_ent  (w_ra_ent),
    .ra_tag  (w_ra_tag),
    .ra_tgt  (w_ra_tgt),
    .rb_idx  (w_up_idx),
    .rb_ent  (w_rb_ent),
    .rb_tag  (w_rb_tag),
    .rb_tgt  (w_rb_tgt),
    .we      (w_we),
    .wa_idx  (w_up_idx),
    .w_ent   (w_wr_ent),
    .w_tag   (w_up_tag),
    .w_tgt   (w_wr_tgt),
    .clr_en  (w_clr),
    .clr_idx (r_ptr)
  );

  // Lookup: table contents are garbage until the sweep finishes.
  assign w_lk_hit = w_ready & w_ra_ent.valid &
                    (w_ra_tag == w_lk_tag);
`ifdef BTP_HYST_EN
  assign w_lk_take = w_lk_hit & w_ra_ent.cnt[1];
`else
  assign w_lk_take = w_lk_hit;
`endif
  assign lk_hit    = w_lk_hit;
  assign lk_target = w_lk_take ? w_ra_tgt
                               : lk_pc + PC_W'(2);

  assign w_up_hit = w_rb_ent.valid & (w_rb_tag == w_up_tag);

  always_comb begin
    w_we     = 1'b0;
    w_wr_ent = '0;
    w_wr_tgt = up_target;
    if (w_ready & up_valid) begin
      unique case (1'b1)
        w_up_hit & up_taken: begin
          w_we           = 1'b1;
          w_wr_ent.valid = 1'b1;
`ifdef BTP_HYST_EN
          w_wr_ent.cnt   = sat_inc(w_rb_ent.cnt);
`endif
        end
        w_up_hit & ~up_taken: begin
          w_we     = 1'b1;
          w_wr_tgt = w_rb_tgt;
`ifdef BTP_HYST_EN
          w_wr_ent.valid = 1'b1;
          w_wr_ent.cnt   = sat_dec(w_rb_ent.cnt);
`else
          w_wr_ent.valid = 1'b0;
`endif
        end
        ~w_up_hit & up_taken: begin
          w_we           = 1'b1;
          w_wr_ent.valid = 1'b1;
`ifdef BTP_HYST_EN
          w_wr_ent.cnt   = ALLOC;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
    end else if (r_state == S_INIT) begin
      r_ptr <= r_ptr + IDX_W'(1);
      if (r_ptr == IDX_W'(ENTRIES - 1)) begin
        r_state <= S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lk_cnt <= '0;
      r_mp_cnt <= '0;
    end else begin
      if (lk_valid & w_ready & ~&r_lk_cnt) begin
        r_lk_cnt <= r_lk_cnt + STAT_W'(1);
      end
      if (up_valid & up_mispredict & w_ready & ~&r_mp_cnt) begin
        r_mp_cnt <= r_mp_cnt + STAT_W'(1);
      end
    end
  end

  assign ready            = w_ready;
  assign stat_lookups     = r_lk_cnt;
  assign stat_mispredicts = r_mp_cnt;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor (16 entries,
// 4-bit tags): directed vector table plus randomized model check.
module tb_branch_target_predictor;

`ifdef BTP_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready;
  logic        lk_valid = 1'b0;
  logic [15:0] lk_pc = '0;
  logic        lk_hit;
  logic [15:0] lk_target;
  logic        up_valid = 1'b0;
  logic [15:0] up_pc = '0;
  logic        up_taken = 1'b0;
  logic [15:0] up_target = '0;
  logic        up_mispredict = 1'b0;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  branch_target_predictor #(
    .ENTRIES (16),
    .PC_W    (16),
    .TAG_W   (4),
    .STAT_W  (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ready            (ready),
    .lk_valid         (lk_valid),
    .lk_pc            (lk_pc),
    .lk_hit           (lk_hit),
    .lk_target        (lk_target),
    .up_valid         (up_valid),
    .up_pc            (up_pc),
    .up_taken         (up_taken),
    .up_target        (up_target),
    .up_mispredict    (up_mispredict),
    .stat_lookups     (stat_lookups),
    .stat_mispredicts (stat_mispredicts)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: an associative map of live entries keyed by
  // index; an absent key is an invalid entry.
  typedef struct {
    int tag;
    int tgt;
    int cnt;
  } ment_t;

  ment_t  m_tab [int];
  longint m_lk;
  longint m_mp;

  function automatic int m_idx(input int pc);
    return (pc >> 1) & 15;
  endfunction

  function automatic int m_tagof(input int pc);
    return (pc >> 5) & 15;
  endfunction

  task automatic m_predict(input int pc,
                           output bit h,
                           output int t);
    int  i;
    bit  take;
    i = m_idx(pc);
    h = m_tab.exists(i) && (m_tab[i].tag == m_tagof(pc));
    take = h && (!HYST || m_tab[i].cnt >= 2);
    t = take ? m_tab[i].tgt : ((pc + 2) % 65536);
  endtask

  task automatic m_update(input bit lkv, input bit uv,
                          input int upc, input bit utk,
                          input int utgt, input bit umis);
    int i;
    bit h;
    if (lkv && m_lk < 64'hFFFF_FFFF) m_lk++;
    if (uv && umis && m_mp < 64'hFFFF_FFFF) m_mp++;
    if (!uv) return;
    i = m_idx(upc);
    h = m_tab.exists(i) && (m_tab[i].tag == m_tagof(upc));
    if (h && utk) begin
      m_tab[i].tgt = utgt;
      if (m_tab[i].cnt < 3) m_tab[i].cnt++;
    end else if (h) begin
      if (HYST) begin
        if (m_tab[i].cnt > 0) m_tab[i].cnt--;
      end else begin
        m_tab.delete(i);
      end
    end else if (utk) begin
      m_tab[i] = '{tag: m_tagof(upc), tgt: utgt, cnt: 2};
    end
  endtask

  task automatic step(input bit lkv, input logic [15:0] lpc,
                      input bit uv, input logic [15:0] upc,
                      input bit utk, input logic [15:0] utgt,
                      input bit umis);
    bit h;
    int t;
    lk_valid = lkv; lk_pc = lpc;
    up_valid = uv; up_pc = upc; up_taken = utk;
    up_target = utgt; up_mispredict = umis;
    m_predict(int'(lpc), h, t);
    @(negedge clk);
    chk("rnd_lk_hit", {31'd0, lk_hit}, {31'd0, h});
    chk("rnd_lk_target", {16'd0, lk_target}, t);
    @(posedge clk);
    m_update(lkv, uv, int'(upc), utk, int'(utgt), umis);
    #1;
  endtask

  task automatic idle_inputs();
    lk_valid = 1'b0; lk_pc = '0;
    up_valid = 1'b0; up_pc = '0; up_taken = 1'b0;
    up_target = '0; up_mispredict = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    logic [15:0] seq;
    n = 0;
    while (!ready && n < 40) begin
      seq = lk_pc + 16'd2;
      @(negedge clk);
      chk("init_lk_hit", {31'd0, lk_hit}, 32'd0);
      chk("init_lk_target", {16'd0, lk_target}, {16'd0, seq});
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, n, 16);
  endtask

  typedef struct {
    bit          uv;
    logic [15:0] upc;
    bit          utk;
    logic [15:0] utgt;
    bit          umis;
    logic [15:0] lpc;
    bit          eh;
    logic [15:0] et;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit uv, logic [15:0] upc, bit utk,
                              logic [15:0] utgt, bit umis,
                              logic [15:0] lpc, bit eh,
                              logic [15:0] et);
    vec_t v;
    v.uv = uv; v.upc = upc; v.utk = utk; v.utgt = utgt;
    v.umis = umis; v.lpc = lpc; v.eh = eh; v.et = et;
    return v;
  endfunction

  function automatic logic [15:0] rpc();
    logic [15:0] p;
    p = 16'($urandom);
    p[8:5] = 4'($urandom_range(0, 2));
    p[4:3] = 2'b00;
    return p;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 0, 16'h0012));
    vecs.push_back(mk(1, 16'h0010, 1, 16'h0100, 0, 16'h0010, 0, 16'h0012));
    vecs.push_back(mk(1, 16'h0010, 1, 16'h0100, 0, 16'h0010, 1, 16'h0100));
    vecs.push_back(mk(1, 16'h0010, 0, 16'h0000, 1, 16'h0010, 1, 16'h0100));
    vecs.push_back(mk(1, 16'h0010, 0, 16'h0000, 1, 16'h0010,
                      HYST, HYST ? 16'h0100 : 16'h0012));
    vecs.push_back(mk(1, 16'h0010, 1, 16'h0100, 0, 16'h0010,
                      HYST, 16'h0012));
    vecs.push_back(mk(1, 16'h0010, 1, 16'h0100, 0, 16'h0010, 1, 16'h0100));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 1, 16'h0100));
    vecs.push_back(mk(1, 16'h0030, 1, 16'h0200, 0, 16'h0030, 0, 16'h0032));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0030, 1, 16'h0200));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 0, 16'h0012));
    vecs.push_back(mk(1, 16'h0010, 1, 16'h0100, 0, 16'h0030, 1, 16'h0200));
    vecs.push_back(mk(1, 16'h0010, 1, 16'h0300, 0, 16'h0010, 1, 16'h0100));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 1, 16'h0300));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'hFFFE, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0050, 0, 16'h0000, 0, 16'h0010, 1, 16'h0300));
    vecs.push_back(mk(0, 16'h0010, 1, 16'h0555, 0, 16'h0010, 1, 16'h0300));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 1, 16'h0300));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 16'h0030, 0, 16'h0032));

    // Power-up reset, then drive traffic during the sweep that must
    // be ignored.
    idle_inputs();
    @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_stat_lookups", stat_lookups, 32'd0);
    chk("rst_stat_mispredicts", stat_mispredicts, 32'd0);
    rst = 1'b0;
    lk_valid = 1'b1; lk_pc = 16'h0040;
    up_valid = 1'b1; up_pc = 16'h0040; up_taken = 1'b1;
    up_target = 16'h0999; up_mispredict = 1'b1;
    wait_ready("init_edges");
    idle_inputs();
    lk_pc = 16'h0040;
    @(negedge clk);
    chk("post_init_lookups", stat_lookups, 32'd0);
    chk("post_init_mispredicts", stat_mispredicts, 32'd0);
    chk("post_init_hit", {31'd0, lk_hit}, 32'd0);
    chk("post_init_target", {16'd0, lk_target}, 32'h0042);
    @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      lk_valid = 1'b1; lk_pc = vecs[k].lpc;
      up_valid = vecs[k].uv; up_pc = vecs[k].upc;
      up_taken = vecs[k].utk; up_target = vecs[k].utgt;
      up_mispredict = vecs[k].umis;
      @(negedge clk);
      chk($sformatf("vec%0d_hit", k), {31'd0, lk_hit},
          {31'd0, vecs[k].eh});
      chk($sformatf("vec%0d_target", k), {16'd0, lk_target},
          {16'd0, vecs[k].et});
      @(posedge clk);
      #1;
    end
    idle_inputs();
    @(negedge clk);
    chk("vec_stat_lookups", stat_lookups, 32'd19);
    chk("vec_stat_mispredicts", stat_mispredicts, 32'd2);
    @(posedge clk);
    #1;

    // Reset in the middle of operation.
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_lookups", stat_lookups, 32'd0);
    chk("mid_rst_mispredicts", stat_mispredicts, 32'd0);
    rst = 1'b0;
    wait_ready("reinit_edges");
    m_tab.delete();
    m_lk = 0;
    m_mp = 0;
    step(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, rpc(), 0, 16'h0000, 0, 16'h0000, 0);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 16'h0010, 1, 16'h0070, 0, 16'h0000, 1);
    end
    chk("stat_lookups_5", stat_lookups, 32'd5);
    chk("stat_mispredicts_2", stat_mispredicts, 32'd2);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = rpc();
      b = ($urandom_range(0, 3) == 0) ? a : rpc();
      step(1'($urandom), a, 1'($urandom), b,
           1'($urandom), 16'($urandom) & 16'hFFFE,
           1'($urandom));
    end
    chk("rnd_stat_lookups", stat_lookups, 32'(m_lk));
    chk("rnd_stat_mispredicts", stat_mispredicts, 32'(m_mp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
